pwm_encoder: RTL and testbench
==============================

# pwm_encoder

Converts a duty value into a binary stream whose high-cycle count over each frame of `CYCLES` clocks equals that value. It performs the inverse of the frame-averaging input filter. It sits at the output side of the function generator, turning sample values into a pin-level signal for an RC-filtered DAC. A ready/valid port accepts new duty values, which are double-buffered so they take effect only on frame boundaries.

## Interface
- `CYCLES`, 500: frame length in clocks; legal range 2 to 2^WIDTH−1.
- `WIDTH`, 16: duty input width.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `duty`  in  WIDTH  requested high cycles per frame
- `duty_valid`  in  1  `duty` is presented
- `duty_ready`  out  1  pending buffer empty; transfer occurs when valid && ready at a rising edge
- `mode`  in  1  0 = PWM (contiguous high run), 1 = first-order sigma-delta (spread ones)
- `out`  out  1  modulated output, registered
- `frame_start`  out  1  one-cycle pulse coincident with position 0 of each frame on `out`

## Operation
- **Frame counter `pos`:**
  - Width $clog2(CYCLES).
  - Counts 0..CYCLES−1 and wraps to 0.
  - The edge where `pos` wraps is the frame boundary.
- **Frame-rate registers:**
  - `active` (duty used in the current frame) and `active_mode` are loaded only at the frame boundary.
  - The value loaded applies to the frame beginning at `pos`=0.
- **Pending register:**
  - A handshake stores min(`duty`, CYCLES) into `pending` and sets `pending_full`.
  - Saturation is applied at load.
  - `duty_ready` = !`pending_full`.
- **At the frame boundary:**
  - If `pending_full`, then `active` ← `pending` and `pending_full` ← 0.
  - `active_mode` ← `mode`, which is always sampled there.
  - If `pending_full` was 0 and a handshake occurs on the same edge, the new value lands in `pending` and applies at the following boundary. No conflict is possible, because ready is low whenever pending is full.
- **PWM mode:** the bit for position p is (p < `active`).
- **Sigma-delta mode:**
  - Accumulator `acc` has width $clog2(2*CYCLES) and is cleared to 0 at each frame boundary.
  - Per position: s = `acc` + `active`.
  - If s ≥ CYCLES, the bit is 1 and `acc` ← s − CYCLES. Otherwise the bit is 0 and `acc` ← s.
  - This yields exactly `active` ones per frame.
- **Edge values:**
  - `active`=0 gives a constant 0.
  - `active`=CYCLES gives a constant 1 in both modes.
- **Reset values:**
  - `pos`=0, `active`=0, `active_mode`=0, `pending_full`=0, `acc`=0.
  - Outputs: `out`=0, `frame_start`=0, `duty_ready`=1 (registered from `pending_full`).
- **Reset mid-frame:** abandons the frame and discards `pending`. Counting restarts from `pos`=0 on the first edge with `rst` low.

## Timing
- `out` and `frame_start` are registered one cycle after the counter position they represent.
  - The first edge with `rst` low computes position 0.
  - `frame_start`=1 and `out`=bit(0) are visible after that edge.
- A new duty accepted at any point in frame F appears on `out` starting at position 0 of frame F+1. The exception is an acceptance on the boundary edge itself, which appears in frame F+2.
- Worst-case latency from handshake to effect: CYCLES+1 clocks.
- `duty_ready` falls the cycle after a handshake and rises the cycle after the boundary that consumes `pending`.
- `frame_start` period is exactly CYCLES clocks. It is never asserted twice within a frame.
- A `mode` change mid-frame has no effect until the next boundary.

## Test plan
Scenarios 1–3 use CYCLES=10, WIDTH=8.

1. **PWM, duty=3, mode=0 after reset:**
   - Frame 0 is all zeros, since `active`=0.
   - Each following frame on `out` is 1110000000.
   - `frame_start` is high with every first bit.
2. **Sigma-delta, duty=3, mode=1:**
   - Each frame is 0001001001 (ones at positions 3, 6, 9).
   - `acc` reads 0 at each boundary.
3. **Extremes:**
   - duty=0 gives constant 0.
   - duty=10 gives constant 1 in both modes.
   - duty=200 saturates and gives constant 1.
4. **Handshake:**
   - Hold `duty_valid`=1 with values 4 then 7. The first is accepted, after which `duty_ready`=0 until the boundary.
   - 7 is accepted on the cycle after the boundary.
   - Resulting frames: 4 high, then 7 high.
5. **Boundary-edge handshake:**
   - Handshake duty=5 exactly on the `pos`=9 edge while pending is empty.
   - The next frame still uses the old duty; the frame after shows 5 high.
6. **Reset mid-frame:**
   - Assert `rst` at `pos`=4 with pending full.
   - All outputs go to reset values and `duty_ready`=1.
   - After release, the first frame is all zeros and `frame_start` recurs every 10 clocks.

Source files
------------

// File: rtl/pwm_encoder.sv
// pwm_encoder
// Turns a duty value into a pin-level bit stream. Over each frame of CYCLES
// clocks, the number of high cycles equals the duty value. There are two
// modulation styles: PWM (one contiguous high run) and first-order
// sigma-delta (ones spread across the frame).
// New duty values arrive on a ready/valid port and wait in a pending buffer.
// They are moved into the active register only at a frame boundary.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   duty         requested high cycles per frame (saturated to CYCLES)
//   duty_valid   duty is presented
//   duty_ready   pending buffer empty; transfer on valid && ready
//   mode         0 = PWM, 1 = sigma-delta (sampled at the frame boundary)
//   out          modulated output, registered
//   frame_start  one-cycle pulse aligned with position 0 of each frame on out

module pwm_encoder #(
    parameter int CYCLES = 500,
    parameter int WIDTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] duty,
    input  logic             duty_valid,
    output logic             duty_ready,
    input  logic             mode,
    output logic             out,
    output logic             frame_start
);

    localparam int PW = $clog2(CYCLES);       // frame position
    localparam int DW = $clog2(CYCLES + 1);   // holds 0..CYCLES
    localparam int AW = $clog2(2 * CYCLES);   // holds acc + active without overflow

    localparam logic [PW-1:0]    LAST   = PW'(CYCLES - 1);
    localparam logic [DW-1:0]    FULL_D = DW'(CYCLES);
    localparam logic [WIDTH-1:0] FULL_W = WIDTH'(CYCLES);
    localparam logic [AW-1:0]    FULL_A = AW'(CYCLES);

    logic [PW-1:0] pos;
    logic [DW-1:0] active;
    logic [DW-1:0] pending;
    logic          active_mode;
    logic          pending_full;
    logic [AW-1:0] acc;

    logic          boundary;
    logic [AW-1:0] sum;
    logic [AW-1:0] acc_next;
    logic          sd_bit;
    logic          pwm_bit;
    logic          bit_now;
    logic [DW-1:0] duty_sat;

    always_comb begin
        boundary = (pos == LAST);
        sum      = acc + AW'(active);
        sd_bit   = (sum >= FULL_A);
        acc_next = sd_bit ? (sum - FULL_A) : sum;
        pwm_bit  = (DW'(pos) < active);
        bit_now  = active_mode ? sd_bit : pwm_bit;
        duty_sat = (duty >= FULL_W) ? FULL_D : DW'(duty);
    end

    assign duty_ready = ~pending_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            pos          <= '0;
            active       <= '0;
            pending      <= '0;
            active_mode  <= 1'b0;
            pending_full <= 1'b0;
            acc          <= '0;
            out          <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            // out and frame_start describe the position that pos held before this edge.
            out         <= bit_now;
            frame_start <= (pos == '0);

            if (boundary) begin
                pos         <= '0;
                acc         <= '0;
                active_mode <= mode;
                if (pending_full) begin
                    active       <= pending;
                    pending_full <= 1'b0;
                end
            end else begin
                pos <= pos + 1'b1;
                acc <= acc_next;
            end

            // This branch runs only while pending is empty, so it never
            // conflicts with the boundary branch that clears pending_full.
            if (duty_valid && !pending_full) begin
                pending      <= duty_sat;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_encoder.sv
module tb_pwm_encoder;

    localparam int CYC = 10;
    localparam int W   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] duty;
    logic         duty_valid;
    logic         duty_ready;
    logic         mode;
    logic         out;
    logic         frame_start;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic o;
        logic fs;
        logic rdy;
        logic chk_rdy;
    } exp_t;

    exp_t sb[$];

    pwm_encoder #(.CYCLES(CYC), .WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .duty        (duty),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .mode        (mode),
        .out         (out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Push expected samples for positions 0..n-1 of one frame.
    task automatic push_frame(input logic [9:0] pat, input logic [9:0] rdy,
                              input logic [9:0] rdy_chk, input int n);
        exp_t e;
        for (int p = 0; p < n; p++) begin
            e.o       = pat[p];
            e.fs      = (p == 0);
            e.rdy     = rdy[p];
            e.chk_rdy = rdy_chk[p];
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        duty_valid = 1'b0;
        duty       = '0;
        mode       = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        duty_valid = 1'b0;
        duty       = '0;
        mode       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 1'b0 || frame_start !== 1'b0 || duty_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset: out=%b fs=%b ready=%b, required 0 0 1",
                         out, frame_start, duty_ready);
            end
        end
        #1;
        rst = 1'b0;
    endtask

    // Each row: duty, mode, expected pattern of frames 1 and 2 (bit p = position p).
    task automatic test_patterns();
        logic [W-1:0] t_duty[8] = '{8'd3, 8'd3, 8'd0, 8'd0, 8'd10, 8'd10, 8'd200, 8'd200};
        logic         t_mode[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [9:0]   t_pat[8]  = '{10'b0000000111, 10'b1001001000, 10'h000, 10'h000,
                                    10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        exp_t e;
        for (int t = 0; t < 8; t++) begin
            do_reset();
            duty       = t_duty[t];
            mode       = t_mode[t];
            duty_valid = 1'b1;
            push_frame(10'h000, 10'b1000000000, 10'h3FF, CYC);
            push_frame(t_pat[t], 10'h3FF, 10'h3FF, CYC);
            push_frame(t_pat[t], 10'h3FF, 10'h3FF, CYC);
            for (int i = 0; i < 3 * CYC; i++) begin
                @(posedge clk);
                #1;
                if (i == 0) duty_valid = 1'b0;
                e = sb.pop_front();
                checks++;
                if (out !== e.o || frame_start !== e.fs) begin
                    errors++;
                    $display("FAIL pattern d=%0d m=%0d sample %0d: out=%b fs=%b, required %b %b",
                             t_duty[t], t_mode[t], i, out, frame_start, e.o, e.fs);
                end
                if (e.chk_rdy) begin
                    checks++;
                    if (duty_ready !== e.rdy) begin
                        errors++;
                        $display("FAIL pattern_ready d=%0d sample %0d: ready=%b, required %b",
                                 t_duty[t], i, duty_ready, e.rdy);
                    end
                end
                if (i % CYC == CYC - 1) begin
                    checks++;
                    if (dut.acc !== '0) begin
                        errors++;
                        $display("FAIL acc_boundary d=%0d m=%0d sample %0d: acc=%0d, required 0",
                                 t_duty[t], t_mode[t], i, dut.acc);
                    end
                end
            end
        end
    endtask

    task automatic test_handshake();
        exp_t e;
        do_reset();
        duty       = 8'd4;
        duty_valid = 1'b1;
        push_frame(10'h000,       10'b1000000000, 10'h3FF, CYC);
        push_frame(10'b0000001111, 10'b1000000000, 10'h3FF, CYC);
        push_frame(10'b0001111111, 10'h3FF,        10'h3FF, CYC);
        for (int i = 0; i < 3 * CYC; i++) begin
            @(posedge clk);
            #1;
            if (i == 0)  duty = 8'd7;
            if (i == 10) duty_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (out !== e.o || frame_start !== e.fs) begin
                errors++;
                $display("FAIL handshake sample %0d: out=%b fs=%b, required %b %b",
                         i, out, frame_start, e.o, e.fs);
            end
            if (e.chk_rdy) begin
                checks++;
                if (duty_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL handshake_ready sample %0d: ready=%b, required %b",
                             i, duty_ready, e.rdy);
                end
            end
        end
    endtask

    task automatic test_boundary_edge();
        exp_t e;
        do_reset();
        duty       = 8'd2;
        duty_valid = 1'b1;
        push_frame(10'h000,        10'b1000000000, 10'h3FF, CYC);
        push_frame(10'b0000000011, 10'b0111111111, 10'h3FF, CYC);
        push_frame(10'b0000000011, 10'b1000000000, 10'h3FF, CYC);
        push_frame(10'b0000011111, 10'h3FF,        10'h3FF, CYC);
        for (int i = 0; i < 4 * CYC; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) duty_valid = 1'b0;
            if (i == 18) begin
                duty       = 8'd5;
                duty_valid = 1'b1;
            end
            if (i == 19) duty_valid = 1'b0;
            e = sb.pop_front();
            checks++;
            if (out !== e.o || frame_start !== e.fs) begin
                errors++;
                $display("FAIL boundary_edge sample %0d: out=%b fs=%b, required %b %b",
                         i, out, frame_start, e.o, e.fs);
            end
            if (e.chk_rdy) begin
                checks++;
                if (duty_ready !== e.rdy) begin
                    errors++;
                    $display("FAIL boundary_edge_ready sample %0d: ready=%b, required %b",
                             i, duty_ready, e.rdy);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        do_reset();
        duty       = 8'd6;
        duty_valid = 1'b1;
        push_frame(10'h000,        10'b1000000000, 10'h3FF, CYC);
        push_frame(10'b0000111111, 10'h000,        10'h000, 4);
        for (int i = 0; i < CYC + 4; i++) begin
            @(posedge clk);
            #1;
            if (i == 0 || i == CYC) duty_valid = 1'b0;
            if (i == CYC - 1) begin
                duty       = 8'd8;
                duty_valid = 1'b1;
            end
            e = sb.pop_front();
            checks++;
            if (out !== e.o || frame_start !== e.fs) begin
                errors++;
                $display("FAIL pre_reset sample %0d: out=%b fs=%b, required %b %b",
                         i, out, frame_start, e.o, e.fs);
            end
        end
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL pending_full_before_reset: ready=%b, required 0", duty_ready);
        end
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 1'b0 || frame_start !== 1'b0 || duty_ready !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset: out=%b fs=%b ready=%b, required 0 0 1",
                         out, frame_start, duty_ready);
            end
        end
        rst = 1'b0;
        for (int f = 0; f < 3; f++) push_frame(10'h000, 10'h3FF, 10'h3FF, CYC);
        for (int i = 0; i < 3 * CYC; i++) begin
            @(posedge clk);
            #1;
            e = sb.pop_front();
            checks++;
            if (out !== e.o || frame_start !== e.fs || duty_ready !== e.rdy) begin
                errors++;
                $display("FAIL post_reset sample %0d: out=%b fs=%b ready=%b, required %b %b %b",
                         i, out, frame_start, duty_ready, e.o, e.fs, e.rdy);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        duty       = '0;
        duty_valid = 1'b0;
        mode       = 1'b0;
        test_reset();
        test_patterns();
        test_handshake();
        test_boundary_edge();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
